// File: rtl/display_pkg.sv
// Shared constants, types and nibble/anode helpers for the four-digit
// multiplexed hex display scanner.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0]            idx_t;
    typedef logic [NIBBLE_W-1:0]   nibble_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    function automatic nibble_t nibble_at(input word_t w, input idx_t i);
        return w[int'(i)*NIBBLE_W +: NIBBLE_W];
    endfunction

    function automatic an_t an_enable(input idx_t i);
        return AN_OFF & ~(an_t'(1) << i);
    endfunction

    // Bit i is set when nibbles i..top are all zero; digit 0 is always shown.
    function automatic an_t lead_zero_mask(input word_t w);
        an_t  m;
        logic all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (w[i*NIBBLE_W +: NIBBLE_W] == '0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Value/strobe inputs and scanned anode/digit/frame outputs of the display
// scanner, bundled for the host side (master) and the scanner (slave).
interface display_scan_if;
    import display_pkg::*;

    word_t   value;
    logic    load;
    logic    lz_blank;
    an_t     an;
    nibble_t digit;
    logic    frame;

    modport master (
        output value, load, lz_blank,
        input  an, digit, frame
    );

    modport slave (
        input  value, load, lz_blank,
        output an, digit, frame
    );

endinterface

// File: rtl/scan_tick.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as the
// digit-slot tick.
module scan_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit time-multiplexed hex display scanner with a shadow value
// register and optional leading-zero blanking; segment decoding is external.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input logic          clk,
    input logic          rst,
    display_scan_if.slave bus
);

    logic    tick;
    idx_t    idx;
    word_t   shadow;
    word_t   shadow_next;
    an_t     blank;
    an_t     an_q;
    nibble_t digit_q;
    logic    frame_q;

    scan_tick #(
        .DIV (DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A load landing on a tick edge must already be visible on that edge.
    assign shadow_next = bus.load ? bus.value : shadow;
    assign blank       = bus.lz_blank ? lead_zero_mask(shadow_next) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (bus.load) begin
            shadow <= bus.value;
        end
    end

    // idx is the slot the next tick brings up, so digit 0 appears on the
    // first tick after reset; outputs only move on ticks, never mid-slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            an_q    <= AN_OFF;
            digit_q <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (tick) begin
                idx     <= idx + 2'd1;
                digit_q <= nibble_at(shadow_next, idx);
                an_q    <= blank[idx] ? AN_OFF : an_enable(idx);
                frame_q <= (idx == 2'd3);
            end
        end
    end

    assign bus.an    = an_q;
    assign bus.digit = digit_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed-vector bench for display_scan at DIV=4: each scenario builds a
// per-cycle table of expected {an, digit, frame} and compares on negedges.
module tb_display_scan;
    import display_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks;
    int   errors;

    logic [8:0] exp_q[$];

    display_scan_if bus ();

    display_scan #(
        .DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic add_slot(input logic [3:0] an_e, input logic [3:0] dig_e,
                            input logic frm_e, input int n);
        for (int c = 0; c < n; c++) begin
            exp_q.push_back({an_e, dig_e, (c == 0) ? frm_e : 1'b0});
        end
    endtask

    // Reset, release with an optional load, and leave the first post-release
    // edge behind; two idle cycles then precede slot 0.
    task automatic start_scan(input logic [15:0] val, input logic lz, input logic do_load);
        @(negedge clk);
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.lz_blank = 1'b0;
        bus.value    = 16'h0000;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        bus.value    = val;
        bus.lz_blank = lz;
        bus.load     = do_load;
        @(negedge clk);
        bus.load = 1'b0;
        exp_q.delete();
        add_slot(AN_OFF, 4'h0, 1'b0, 2);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.value    = 16'hFFFF;
        bus.lz_blank = 1'b0;
        exp_q.delete();
        add_slot(AN_OFF, 4'h0, 1'b0, 6);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        add_slot(4'b1101, 4'h0, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL reset cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
            if (k == 2) begin
                rst      = 1'b0;
                bus.load = 1'b0;
            end
        end
    endtask

    task automatic test_basic_scan();
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int s = 0; s < 2; s++) begin
            add_slot(4'b1110, 4'h4, 1'b0, 4);
            add_slot(4'b1101, 4'h3, 1'b0, 4);
            add_slot(4'b1011, 4'h2, 1'b0, 4);
            add_slot(4'b0111, 4'h1, 1'b1, 4);
        end
        add_slot(4'b1110, 4'h4, 1'b0, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL basic_scan cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
        end
    endtask

    task automatic test_lz_blank();
        start_scan(16'h0050, 1'b1, 1'b1);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        add_slot(4'b1101, 4'h5, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b1, 4);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        add_slot(4'b1101, 4'h5, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b0, 4);
        add_slot(4'b0111, 4'h0, 1'b1, 4);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        add_slot(4'b1101, 4'h5, 1'b0, 4);
        add_slot(4'b1011, 4'h0, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL lz_blank cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
            if (k == 27) begin
                bus.lz_blank = 1'b0;
            end
        end
    endtask

    task automatic test_all_zero();
        start_scan(16'h0000, 1'b1, 1'b1);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b0, 4);
        add_slot(AN_OFF,  4'h0, 1'b1, 4);
        add_slot(4'b1110, 4'h0, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL all_zero cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
        end
    endtask

    task automatic test_mid_slot_load();
        start_scan(16'h1234, 1'b0, 1'b1);
        add_slot(4'b1110, 4'h4, 1'b0, 4);
        add_slot(4'b1101, 4'h3, 1'b0, 4);
        add_slot(4'b1011, 4'hB, 1'b0, 4);
        add_slot(4'b0111, 4'hA, 1'b1, 4);
        add_slot(4'b1110, 4'hD, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL mid_slot_load cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
            if (k == 7) begin
                bus.value = 16'hABCD;
                bus.load  = 1'b1;
            end else if (k == 8) begin
                bus.load = 1'b0;
            end
        end
    endtask

    task automatic test_load_on_tick();
        start_scan(16'h1234, 1'b0, 1'b1);
        add_slot(4'b1110, 4'h4, 1'b0, 4);
        add_slot(4'b1101, 4'h7, 1'b0, 4);
        add_slot(4'b1011, 4'h6, 1'b0, 4);
        add_slot(4'b0111, 4'h5, 1'b1, 4);
        add_slot(4'b1110, 4'h8, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL load_on_tick cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
            if (k == 5) begin
                bus.value = 16'h5678;
                bus.load  = 1'b1;
            end else if (k == 6) begin
                bus.load = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        start_scan(16'h1234, 1'b0, 1'b1);
        add_slot(4'b1110, 4'h4, 1'b0, 4);
        add_slot(4'b1101, 4'h3, 1'b0, 4);
        add_slot(4'b1011, 4'h2, 1'b0, 2);
        add_slot(AN_OFF,  4'h0, 1'b0, 9);
        add_slot(4'b1110, 4'h4, 1'b0, 4);
        add_slot(4'b1101, 4'h3, 1'b0, 4);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.digit, bus.frame} !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL reset_mid_scan cyc %0d: got an=%b digit=%h frame=%b, want an=%b digit=%h frame=%b",
                         k, bus.an, bus.digit, bus.frame, exp_q[k][8:5], exp_q[k][4:1], exp_q[k][0]);
            end
            if (k == 11) begin
                rst = 1'b1;
            end else if (k == 17) begin
                rst       = 1'b0;
                bus.value = 16'h1234;
                bus.load  = 1'b1;
            end else if (k == 18) begin
                bus.load = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_all_zero();
        test_mid_slot_load();
        test_load_on_tick();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
